// File: rtl/usb_rx_pkt_ctrl.sv
// USB RX packet sequencer: drains the RX FIFO, checks PID and length, streams payload.
// Optional CRC16 residue check on data packets: define USB_RX_PKT_CTRL_CRC16_EN.
module usb_rx_pkt_ctrl #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] r_data,
    input  logic       empty,
    input  logic       rcving,
    input  logic       r_error,
    output logic       r_enable,
    output logic [3:0] pid,
    output logic       pid_valid,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [6:0] pkt_len,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic       busy
);

    localparam int LIM = MAX_LEN + 2;

    typedef enum logic [2:0] {IDLE, GET_PID, PAYLOAD, FLUSH, DONE} state_t;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [3:0] pid_q, pid_d;
    logic       pid_valid_q, pid_valid_d;
    logic [7:0] data_q, data_d;
    logic       dv_q, dv_d;
    logic [6:0] len_q, len_d;
    logic       done_q, done_d;
    logic       perr_q, perr_d;
    logic       go_done;
    logic       len_bad;
    logic [6:0] len_calc;
    logic       crc_bad;

    // Length rule and reported length depend on the PID class of the current packet.
    always_comb begin
        len_bad  = 1'b0;
        len_calc = cnt_q;
        case (pid_q[1:0])
            2'b01:   len_bad = (cnt_q != 7'd2);
            2'b10:   len_bad = (cnt_q != 7'd0);
            2'b11: begin
                len_bad  = (cnt_q < 7'd2) || (int'(cnt_q) > LIM);
                len_calc = (cnt_q >= 7'd2) ? cnt_q - 7'd2 : 7'd0;
            end
            default: len_bad = (int'(cnt_q) > LIM);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        pid_d       = pid_q;
        pid_valid_d = 1'b0;
        data_d      = data_q;
        dv_d        = 1'b0;
        len_d       = len_q;
        done_d      = 1'b0;
        perr_d      = perr_q;
        r_enable    = 1'b0;
        go_done     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 7'd0;
                err_d = 1'b0;
                if (rcving || !empty) state_d = GET_PID;
            end
            GET_PID: begin
                r_enable = !empty;
                if (r_error) begin
                    err_d   = 1'b1;
                    state_d = FLUSH;
                end else if (!empty) begin
                    if (r_data[7:4] == ~r_data[3:0]) begin
                        pid_d       = r_data[3:0];
                        pid_valid_d = 1'b1;
                        state_d     = PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FLUSH;
                    end
                end else if (!rcving) begin
                    err_d   = 1'b1;
                    go_done = 1'b1;
                end
            end
            PAYLOAD: begin
                r_enable = !empty;
                if (r_error) begin
                    err_d   = 1'b1;
                    state_d = FLUSH;
                end else if (!empty) begin
                    // A byte beyond the longest legal payload is discarded, not delivered.
                    if (int'(cnt_q) >= LIM) begin
                        err_d   = 1'b1;
                        state_d = FLUSH;
                    end else begin
                        data_d = r_data;
                        dv_d   = 1'b1;
                        cnt_d  = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;
                    end
                end else if (!rcving) begin
                    go_done = 1'b1;
                end
            end
            FLUSH: begin
                r_enable = !empty;
                if (empty && !rcving) go_done = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status is latched on entry to DONE so pkt_done is high while the FSM sits in DONE.
        if (go_done) begin
            state_d = DONE;
            done_d  = 1'b1;
            len_d   = len_calc;
            perr_d  = err_d | len_bad | crc_bad;
        end
    end

`ifdef USB_RX_PKT_CTRL_CRC16_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (state_q == IDLE) crc_d = 16'hFFFF;
        else if (dv_d && pid_q[1:0] == 2'b11) crc_d = crc_step(crc_q, r_data);
        crc_bad = (pid_q[1:0] == 2'b11) && (crc_q != 16'hB001);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) crc_q <= 16'hFFFF;
        else        crc_q <= crc_d;
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= 7'd0;
            err_q       <= 1'b0;
            pid_q       <= 4'd0;
            pid_valid_q <= 1'b0;
            data_q      <= 8'd0;
            dv_q        <= 1'b0;
            len_q       <= 7'd0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            pid_q       <= pid_d;
            pid_valid_q <= pid_valid_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            len_q       <= len_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
        end
    end

    assign pid        = pid_q;
    assign pid_valid  = pid_valid_q;
    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign pkt_len    = len_q;
    assign pkt_done   = done_q;
    assign pkt_err    = perr_q;
    assign busy       = (state_q != IDLE);

endmodule
